// File: rtl/grab_bag_pkg.sv
// grab_bag_pkg: shared constants and helpers for the grab-bag PWM/sigma-delta DAC tile
package grab_bag_pkg;

    localparam logic MODE_PWM = 1'b0;
    localparam logic MODE_SD  = 1'b1;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 8;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/grab_bag_pwm_dac_if.sv
// grab_bag_pwm_dac_if: duty-value write strobe bus into the DAC shadow registers
interface grab_bag_pwm_dac_if #(
    parameter int CHANNELS = grab_bag_pkg::DEF_CHANNELS,
    parameter int WIDTH    = grab_bag_pkg::DEF_WIDTH
);

    logic                                     wr_en;
    logic [grab_bag_pkg::addr_w(CHANNELS)-1:0] wr_addr;
    logic [WIDTH-1:0]                         wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/grab_bag_pwm_chan.sv
// grab_bag_pwm_chan: one DAC channel with double-buffered duty, PWM compare and sigma-delta accumulator
module grab_bag_pwm_chan
    import grab_bag_pkg::*;
#(
    parameter int   WIDTH = DEF_WIDTH,
    parameter logic INV   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             mode,
    input  logic             wrap,
    input  logic             we,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] cnt,
    output logic             out
);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_next;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   acc_next;
    logic             bit_val;

    // a write landing on the wrap edge must reach active on that same edge
    assign shadow_next = we ? wr_data : shadow;
    // the carry only ever exists in acc_next; the stored accumulator keeps the low bits
    assign acc_next    = {1'b0, acc} + {1'b0, active};
    assign bit_val     = (mode == MODE_SD) ? acc_next[WIDTH] : (cnt < active);

    // shadow/active/accumulator state and output register; disabled cycles freeze state and drive 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            acc    <= '0;
            out    <= 1'b0;
        end else if (ena) begin
            shadow <= shadow_next;
            acc    <= acc_next[WIDTH-1:0];
            out    <= bit_val ^ INV;
            if (wrap) active <= shadow_next;
        end else begin
            out <= 1'b0;
        end
    end

endmodule

// File: rtl/grab_bag_pwm_dac.sv
// grab_bag_pwm_dac: multi-channel PWM / sigma-delta DAC driver with shared period counter
module grab_bag_pwm_dac
    import grab_bag_pkg::*;
#(
    parameter int                  CHANNELS = DEF_CHANNELS,
    parameter int                  WIDTH    = DEF_WIDTH,
    parameter logic [CHANNELS-1:0] INVERT   = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [CHANNELS-1:0] mode_sel,
    grab_bag_pwm_dac_if.slave   bus,
    output logic [CHANNELS-1:0] dac_out,
    output logic                period_wrap
);

    localparam int AW = addr_w(CHANNELS);

    logic [WIDTH-1:0] cnt;
    logic             wrap;

    assign wrap = ena && (cnt == '1);

    // shared period counter and registered wrap pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            period_wrap <= 1'b0;
        end else begin
            period_wrap <= wrap;
            if (ena) cnt <= cnt + WIDTH'(1);
        end
    end

    // matching only real channel indices drops out-of-range addresses for free
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic we;
        assign we = ena && bus.wr_en && (bus.wr_addr == AW'(c));
        grab_bag_pwm_chan #(
            .WIDTH(WIDTH),
            .INV  (INVERT[c])
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .ena    (ena),
            .mode   (mode_sel[c]),
            .wrap   (wrap),
            .we     (we),
            .wr_data(bus.wr_data),
            .cnt    (cnt),
            .out    (dac_out[c])
        );
    end

endmodule
